// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480 @ 60 Hz timing constants for the sync generator, the display
//   path and the game logic, plus the registered control-bundle type and a
//   counter-width helper.
package vga_timing_pkg;

   // Default timing, pixels (horizontal) and lines (vertical).
   localparam int unsigned ClkDiv   = 4;
   localparam int unsigned HDisplay = 640;
   localparam int unsigned HFront   = 16;
   localparam int unsigned HSync    = 96;
   localparam int unsigned HBack    = 48;
   localparam int unsigned VDisplay = 480;
   localparam int unsigned VFront   = 10;
   localparam int unsigned VSync    = 2;
   localparam int unsigned VBack    = 33;

   localparam int unsigned HTotal     = HDisplay + HFront + HSync + HBack;  // 800
   localparam int unsigned VTotal     = VDisplay + VFront + VSync + VBack;  // 525
   localparam int unsigned HSyncStart = HDisplay + HFront;                  // 656
   localparam int unsigned HSyncEnd   = HSyncStart + HSync - 1;             // 751
   localparam int unsigned VSyncStart = VDisplay + VFront;                  // 490
   localparam int unsigned VSyncEnd   = VSyncStart + VSync - 1;             // 491

   // Game logic updates its state here, safely outside the visible area.
   localparam int unsigned RefreshX = 0;
   localparam int unsigned RefreshY = VDisplay + 1;

   // Width of the x/y coordinate outputs.
   localparam int unsigned CoordW = 10;

   // Registered per-pixel control outputs; sync levels are active-low.
   typedef struct packed {
      logic display_on;
      logic hsync;
      logic vsync;
   } vga_ctrl_t;

   localparam vga_ctrl_t CtrlReset = '{display_on: 1'b1, hsync: 1'b1, vsync: 1'b1};

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter
//   Counts 0..N-1 on enabled clocks and wraps to 0.
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset, count returns to 0
//   en_i         advance enable
//   count_o      current count (registered)
//   count_next_o value the count takes on the next clock edge
//   wrap_o       high when enabled at N-1, i.e. the count wraps on this edge
module mod_n_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned N = 2,
   parameter int unsigned W = cnt_width(N)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   output logic [W-1:0] count_o,
   output logic [W-1:0] count_next_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] Last = W'(N - 1);

   logic [W-1:0] count_q, count_d;
   logic         at_last;

   // With N == 1, Last is 0 and the count never leaves 0.
   assign at_last = (count_q == Last);

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = at_last ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o      = count_q;
   assign count_next_o = count_d;
   assign wrap_o       = en_i & at_last;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   VGA timing generator: divides the system clock down to the pixel rate and
//   produces pixel coordinates, the active-video flag, active-low sync pulses
//   and a once-per-frame strobe.
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   pixel_tick  one-clock enable, once every CLK_DIV clocks
//   x, y        pixel / line coordinates
//   display_on  high inside the visible area (registered)
//   hsync       active-low horizontal sync (registered)
//   vsync       active-low vertical sync (registered)
//   frame_tick  one-clock pulse on the last pixel of each frame
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV   = ClkDiv,
   parameter int unsigned H_DISPLAY = HDisplay,
   parameter int unsigned H_FRONT   = HFront,
   parameter int unsigned H_SYNC    = HSync,
   parameter int unsigned H_BACK    = HBack,
   parameter int unsigned V_DISPLAY = VDisplay,
   parameter int unsigned V_FRONT   = VFront,
   parameter int unsigned V_SYNC    = VSync,
   parameter int unsigned V_BACK    = VBack
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              pixel_tick,
   output logic [CoordW-1:0] x,
   output logic [CoordW-1:0] y,
   output logic              display_on,
   output logic              hsync,
   output logic              vsync,
   output logic              frame_tick
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DivW    = cnt_width(CLK_DIV);

   localparam logic [CoordW-1:0] HDispL   = CoordW'(H_DISPLAY);
   localparam logic [CoordW-1:0] VDispL   = CoordW'(V_DISPLAY);
   localparam logic [CoordW-1:0] HSyncLoL = CoordW'(H_DISPLAY + H_FRONT);
   localparam logic [CoordW-1:0] HSyncHiL = CoordW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [CoordW-1:0] VSyncLoL = CoordW'(V_DISPLAY + V_FRONT);
   localparam logic [CoordW-1:0] VSyncHiL = CoordW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [DivW-1:0]   div, div_next;
   logic [CoordW-1:0] x_next, y_next;
   logic              h_wrap, v_wrap;

   // Pixel-rate divider: free running, its wrap is the pixel enable.
   mod_n_counter #(
      .N (CLK_DIV),
      .W (DivW)
   ) u_div (
      .clk_i        (clock),
      .rst_ni       (reset_n),
      .en_i         (1'b1),
      .count_o      (div),
      .count_next_o (div_next),
      .wrap_o       (pixel_tick)
   );

   mod_n_counter #(
      .N (H_TOTAL),
      .W (CoordW)
   ) u_h_cnt (
      .clk_i        (clock),
      .rst_ni       (reset_n),
      .en_i         (pixel_tick),
      .count_o      (x),
      .count_next_o (x_next),
      .wrap_o       (h_wrap)
   );

   mod_n_counter #(
      .N (V_TOTAL),
      .W (CoordW)
   ) u_v_cnt (
      .clk_i        (clock),
      .rst_ni       (reset_n),
      .en_i         (h_wrap),
      .count_o      (y),
      .count_next_o (y_next),
      .wrap_o       (v_wrap)
   );

   // Only the divider's wrap is needed at this level.
   logic unused_div;
   assign unused_div = ^{div, div_next};

   // Vertical wrap already implies pixel_tick, last pixel and last line.
   assign frame_tick = v_wrap;

   // Decode from the next counter values so the registered outputs change on
   // the same edge as x/y.
   vga_ctrl_t ctrl_d, ctrl_q;

   always_comb begin
      ctrl_d            = ctrl_q;
      ctrl_d.display_on = (x_next < HDispL) && (y_next < VDispL);
      ctrl_d.hsync      = !((x_next >= HSyncLoL) && (x_next <= HSyncHiL));
      ctrl_d.vsync      = !((y_next >= VSyncLoL) && (y_next <= VSyncHiL));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q <= CtrlReset;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign display_on = ctrl_q.display_on;
   assign hsync      = ctrl_q.hsync;
   assign vsync      = ctrl_q.vsync;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Directed checks of vga_sync_gen: default 640x480 timing with CLK_DIV = 4,
//   and a shrunken timing set with CLK_DIV = 1 short enough to run whole frames.
module tb_vga_sync_gen;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       rst_a_n, rst_b_n;
   logic       pt_a, de_a, hs_a, vs_a, ft_a;
   logic       pt_b, de_b, hs_b, vs_b, ft_b;
   logic [9:0] x_a, y_a, x_b, y_b;

   int n_checks = 0;
   int n_errors = 0;

   // Clock edges seen since each reset release.
   int e_a = 0;
   int e_b = 0;

   always @(posedge clock) begin
      if (!rst_a_n) e_a <= 0;
      else          e_a <= e_a + 1;
      if (!rst_b_n) e_b <= 0;
      else          e_b <= e_b + 1;
   end

   vga_sync_gen u_dut_a (
      .clock      (clock),
      .reset_n    (rst_a_n),
      .pixel_tick (pt_a),
      .x          (x_a),
      .y          (y_a),
      .display_on (de_a),
      .hsync      (hs_a),
      .vsync      (vs_a),
      .frame_tick (ft_a)
   );

   // Small timing: H 8+2+3+2 = 15 (hsync low x 10..12),
   //               V 6+2+2+3 = 13 (vsync low y 8..9), frame = 195 clocks.
   vga_sync_gen #(
      .CLK_DIV   (1),
      .H_DISPLAY (8),
      .H_FRONT   (2),
      .H_SYNC    (3),
      .H_BACK    (2),
      .V_DISPLAY (6),
      .V_FRONT   (2),
      .V_SYNC    (2),
      .V_BACK    (3)
   ) u_dut_b (
      .clock      (clock),
      .reset_n    (rst_b_n),
      .pixel_tick (pt_b),
      .x          (x_b),
      .y          (y_b),
      .display_on (de_b),
      .hsync      (hs_b),
      .vsync      (vs_b),
      .frame_tick (ft_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic goto_a(input int t);
      int guard = 0;
      while (e_a < t && guard < 20000) begin
         @(negedge clock);
         guard++;
      end
   endtask

   task automatic goto_b(input int t);
      int guard = 0;
      while (e_b < t && guard < 20000) begin
         @(negedge clock);
         guard++;
      end
   endtask

   int n_ft, ft_first, ft_second;

   initial begin
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      repeat (3) @(negedge clock);

      // Reset state, default timing.
      check_eq("rst_x", x_a, 0);
      check_eq("rst_y", y_a, 0);
      check_eq("rst_pt", pt_a, 0);
      check_eq("rst_de", de_a, 1);
      check_eq("rst_hs", hs_a, 1);
      check_eq("rst_vs", vs_a, 1);
      check_eq("rst_ft", ft_a, 0);

      rst_a_n = 1'b1;
      goto_a(3);
      check_eq("a3_pt", pt_a, 1);
      check_eq("a3_x", x_a, 0);
      goto_a(4);
      check_eq("a4_x", x_a, 1);
      check_eq("a4_pt", pt_a, 0);
      check_eq("a4_y", y_a, 0);
      check_eq("a4_hs", hs_a, 1);
      check_eq("a4_vs", vs_a, 1);
      check_eq("a4_de", de_a, 1);
      goto_a(7);
      check_eq("a7_pt", pt_a, 1);
      goto_a(8);
      check_eq("a8_x", x_a, 2);

      goto_a(2556);
      check_eq("x639_x", x_a, 639);
      check_eq("x639_de", de_a, 1);
      goto_a(2560);
      check_eq("x640_x", x_a, 640);
      check_eq("x640_de", de_a, 0);
      goto_a(2623);
      check_eq("x655_x", x_a, 655);
      check_eq("x655_hs", hs_a, 1);
      goto_a(2624);
      check_eq("x656_x", x_a, 656);
      check_eq("x656_hs", hs_a, 0);
      goto_a(3007);
      check_eq("x751_hs", hs_a, 0);
      goto_a(3008);
      check_eq("x752_x", x_a, 752);
      check_eq("x752_hs", hs_a, 1);
      goto_a(3199);
      check_eq("x799_x", x_a, 799);
      check_eq("x799_de", de_a, 0);
      check_eq("x799_pt", pt_a, 1);
      check_eq("x799_ft", ft_a, 0);
      goto_a(3200);
      check_eq("wrap_x", x_a, 0);
      check_eq("wrap_y", y_a, 1);
      check_eq("wrap_de", de_a, 1);

      // Async reset inside hsync at x = 700, y = 1.
      goto_a(6000);
      check_eq("mid_x", x_a, 700);
      check_eq("mid_y", y_a, 1);
      check_eq("mid_hs", hs_a, 0);
      rst_a_n = 1'b0;
      #1;
      check_eq("arst_x", x_a, 0);
      check_eq("arst_y", y_a, 0);
      check_eq("arst_hs", hs_a, 1);
      check_eq("arst_de", de_a, 1);
      check_eq("arst_pt", pt_a, 0);
      @(negedge clock);
      @(negedge clock);
      rst_a_n = 1'b1;
      goto_a(3);
      check_eq("rel_x", x_a, 0);
      check_eq("rel_pt", pt_a, 1);
      goto_a(4);
      check_eq("rel_x1", x_a, 1);

      // Small timing, CLK_DIV = 1.
      rst_b_n = 1'b1;
      @(negedge clock);
      check_eq("b1_pt", pt_b, 1);
      check_eq("b1_x", x_b, 1);
      goto_b(9);
      check_eq("b9_hs", hs_b, 1);
      goto_b(10);
      check_eq("b10_x", x_b, 10);
      check_eq("b10_hs", hs_b, 0);
      check_eq("b10_pt", pt_b, 1);
      goto_b(12);
      check_eq("b12_hs", hs_b, 0);
      goto_b(13);
      check_eq("b13_hs", hs_b, 1);
      goto_b(14);
      check_eq("b14_x", x_b, 14);
      goto_b(15);
      check_eq("b15_x", x_b, 0);
      check_eq("b15_y", y_b, 1);
      goto_b(82);
      check_eq("b82_de", de_b, 1);
      goto_b(90);
      check_eq("b90_y", y_b, 6);
      check_eq("b90_de", de_b, 0);
      goto_b(119);
      check_eq("b119_vs", vs_b, 1);
      goto_b(120);
      check_eq("b120_y", y_b, 8);
      check_eq("b120_vs", vs_b, 0);
      goto_b(149);
      check_eq("b149_vs", vs_b, 0);
      goto_b(150);
      check_eq("b150_vs", vs_b, 1);

      // Frame strobe: expected at edges 194 and 389 only.
      n_ft      = 0;
      ft_first  = -1;
      ft_second = -1;
      while (e_b < 390) begin
         @(negedge clock);
         if (ft_b) begin
            n_ft++;
            if (ft_first < 0) ft_first = e_b;
            else              ft_second = e_b;
         end
      end
      check_eq("ft_count", n_ft, 2);
      check_eq("ft_first", ft_first, 194);
      check_eq("ft_second", ft_second, 389);
      check_eq("frame_x", x_b, 0);
      check_eq("frame_y", y_b, 0);

      // Async reset inside hsync at x = 11, y = 3.
      goto_b(446);
      check_eq("bmid_x", x_b, 11);
      check_eq("bmid_y", y_b, 3);
      check_eq("bmid_hs", hs_b, 0);
      rst_b_n = 1'b0;
      #1;
      check_eq("brst_x", x_b, 0);
      check_eq("brst_y", y_b, 0);
      check_eq("brst_hs", hs_b, 1);
      @(negedge clock);
      @(negedge clock);
      rst_b_n = 1'b1;
      goto_b(9);
      check_eq("brel9_hs", hs_b, 1);
      goto_b(10);
      check_eq("brel10_hs", hs_b, 0);
      check_eq("brel10_x", x_b, 10);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
